// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider producing {remainder, quotient} for DIV/DIVU
// Ports: clk, rst (sync, active-high); start_i request held until ready_o; annul_i abort;
//        signed_div_i 1=DIV 0=DIVU; opdata1_i dividend; opdata2_i divisor;
//        result_o {rem, quo}; ready_o result valid.
// Optional: DIV_EARLY_OUT_EN sends a zero dividend through the short DIVZERO path.
module ex_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);
    localparam int CW = $clog2(WIDTH) + 1;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] rem, quo, dvs, raw, abs1, abs2, rem_n, quo_n, fix_r, fix_q;
    logic [WIDTH:0] sh;
    logic [CW-1:0] cnt;
    logic s1, s2, qneg, rneg, dz, accept, quit, last, no_bor;
    assign s1 = signed_div_i & opdata1_i[WIDTH-1];
    assign s2 = signed_div_i & opdata2_i[WIDTH-1];
    assign abs1 = s1 ? -opdata1_i : opdata1_i;
    assign abs2 = s2 ? -opdata2_i : opdata2_i;
    assign accept = state == IDLE && start_i && !annul_i;
    assign quit = annul_i || !start_i;
    assign last = cnt == CW'(WIDTH - 1);
    // Shifted partial remainder needs one extra bit before the trial subtract.
    assign sh = {rem, quo[WIDTH-1]};
    assign no_bor = sh >= {1'b0, dvs};
    assign rem_n = no_bor ? WIDTH'(sh - {1'b0, dvs}) : sh[WIDTH-1:0];
    assign quo_n = {quo[WIDTH-2:0], no_bor};
    // The last iteration folds the sign fix in so DONE registers the final value.
    assign fix_q = qneg ? -quo_n : quo_n;
    assign fix_r = rneg ? -rem_n : rem_n;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !accept ? IDLE :
                               (abs2 == '0 || (EARLY && abs1 == '0)) ? DIVZERO : BUSY;
            DIVZERO: state_n = quit ? IDLE : DONE;
            BUSY:    state_n = quit ? IDLE : last ? DONE : BUSY;
            DONE:    state_n = quit ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            raw      <= '0;
            cnt      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            dz       <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            if (accept) begin
                rem  <= '0;
                quo  <= abs1;
                dvs  <= abs2;
                raw  <= opdata1_i;
                cnt  <= '0;
                qneg <= s1 ^ s2;
                rneg <= s1;
                dz   <= abs2 == '0;
            end else if (state == BUSY) begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt + 1'b1;
            end
            result_o <= state_n != DONE ? '0 :
                        state == DONE ? result_o :
                        state == DIVZERO ? (dz ? {raw, {WIDTH{1'b1}}} : '0) :
                        {fix_r, fix_q};
            ready_o  <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed self-checking bench for ex_div_unit
module tb_ex_div_unit;
    logic        clk = 0;
    logic        rst = 1;
    logic        start_i = 0;
    logic        annul_i = 0;
    logic        signed_div_i = 0;
    logic [31:0] opdata1_i = 0;
    logic [31:0] opdata2_i = 0;
    logic [63:0] result_o;
    logic        ready_o;
    int checks = 0;
    int failures = 0;
    ex_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
        .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .result_o(result_o), .ready_o(ready_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask
    // Accept edge counts as cycle 1; operands are scrambled right after it.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int ecyc, input logic [63:0] eres, input string nm);
        int cyc = 0;
        bit seen = 0;
        logic [63:0] held;
        @(negedge clk);
        opdata1_i = a;
        opdata2_i = b;
        signed_div_i = s;
        start_i = 1;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_div_i = ~s;
            end
            seen = ready_o;
        end
        chk({nm, "_cycle"}, 64'(cyc), 64'(ecyc));
        chk({nm, "_result"}, result_o, eres);
        held = result_o;
        @(negedge clk);
        chk({nm, "_hold_ready"}, 64'(ready_o), 64'd1);
        chk({nm, "_hold_result"}, result_o, held);
        start_i = 0;
        @(negedge clk);
        chk({nm, "_drop_ready"}, 64'(ready_o), 64'd0);
        chk({nm, "_drop_result"}, result_o, 64'd0);
    endtask
    initial begin
        bit any_ready;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 0;
        run(32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, "divu_100_7");
        run(32'hFFFFFFF9, 32'd2, 1'b1, 33, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_m7_2");
        run(32'd5, 32'd0, 1'b0, 2, {32'd5, 32'hFFFFFFFF}, "divu_5_0");
        run(32'hFFFFFFFB, 32'd0, 1'b1, 2, {32'hFFFFFFFB, 32'hFFFFFFFF}, "div_m5_0");
        run(32'h80000000, 32'hFFFFFFFF, 1'b1, 33, {32'd0, 32'h80000000}, "div_ovf");
        run(32'd7, 32'hFFFFFFFE, 1'b1, 33, {32'd1, 32'hFFFFFFFD}, "div_7_m2");
        run(32'hFFFFFFFF, 32'd16, 1'b0, 33, {32'd15, 32'h0FFFFFFF}, "divu_max_16");
        // Annul partway through BUSY.
        any_ready = 0;
        @(negedge clk);
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        signed_div_i = 0;
        start_i = 1;
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
            any_ready |= ready_o;
        end
        annul_i = 1;
        @(posedge clk);
        @(negedge clk);
        any_ready |= ready_o;
        annul_i = 0;
        start_i = 0;
        repeat (40) begin
            @(negedge clk);
            any_ready |= ready_o;
        end
        chk("annul_no_ready", 64'(any_ready), 64'd0);
        run(32'd9, 32'd3, 1'b0, 33, {32'd0, 32'd3}, "divu_9_3");
`ifdef DIV_EARLY_OUT_EN
        run(32'd0, 32'd7, 1'b0, 2, 64'd0, "divu_0_7");
`else
        run(32'd0, 32'd7, 1'b0, 33, 64'd0, "divu_0_7");
`endif
        // Dropping start_i in BUSY abandons the operation.
        any_ready = 0;
        @(negedge clk);
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i = 1;
        repeat (4) @(negedge clk);
        start_i = 0;
        repeat (40) begin
            @(negedge clk);
            any_ready |= ready_o;
        end
        chk("drop_busy_no_ready", 64'(any_ready), 64'd0);
        // Reset in BUSY.
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1;
        repeat (6) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("rst_busy_ready", 64'(ready_o), 64'd0);
        chk("rst_busy_result", result_o, 64'd0);
        rst = 0;
        start_i = 0;
        run(32'd81, 32'd9, 1'b0, 33, {32'd0, 32'd9}, "post_rst_81_9");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
